// File: rtl/axis_bram_capture_v2_if.sv
// AXI4-Stream beat bundle between a stream source and the BRAM capture block.
interface axis_bram_capture_v2_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tstrb, tlast, tvalid, input tready);
  modport slave  (input tdata, tstrb, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_bram_capture_v2.sv
// Stream-to-BRAM capture: start/stop FSM, single-shot or circular addressing,
// TLAST frame tracking, byte-enable writes and a shiftable debug tap buffer.
module axis_bram_capture_v2 #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 12,
  parameter int BRAM_WORDS    = 4096,
  parameter int TAP_DEPTH     = 16,
  parameter int CIRCULAR      = 0,
  parameter int STOP_ON_TLAST = 0
) (
  input  logic                         s00_axis_aclk,
  input  logic                         s00_axis_areset,
  axis_bram_capture_v2_if.slave        s00_axis,
  input  logic                         capture_start,
  input  logic                         capture_stop,
  input  logic                         tap_shift,
  input  logic [$clog2(TAP_DEPTH)-1:0] tap_sel,
  output logic [DATA_WIDTH-1:0]        tap_out,
  output logic                         bram_clk,
  output logic                         bram_en,
  output logic [DATA_WIDTH/8-1:0]      bram_we,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  output logic [DATA_WIDTH-1:0]        bram_wdata,
  output logic [ADDR_WIDTH:0]          word_count,
  output logic                         frame_done,
  output logic [ADDR_WIDTH:0]          frame_len,
  output logic                         full,
  output logic                         wrapped,
  output logic                         busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   MAX_COUNT = (ADDR_WIDTH + 1)'(BRAM_WORDS);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [ADDR_WIDTH:0]       word_count_reg, frame_cnt_reg, frame_len_reg;
  logic                      full_reg, wrapped_reg, frame_done_reg, bram_en_reg;
  logic [DATA_WIDTH/8-1:0]   bram_we_reg;
  logic [ADDR_WIDTH-1:0]     bram_addr_reg;
  logic [DATA_WIDTH-1:0]     bram_wdata_reg, last_word_reg;
  logic                      tap_shift_reg;
  logic [DATA_WIDTH-1:0]     tap_reg [TAP_DEPTH];
  logic [DATA_WIDTH-1:0]     tap_in  [TAP_DEPTH];

  logic beat_accept, end_full, end_frame, tap_edge, shift_en;
  logic [DATA_WIDTH-1:0] shift_in;

  // Start and stop pulses steal the cycle, so a beat offered alongside them is refused.
  assign s00_axis.tready = (state_reg == CAPTURE) && !capture_start && !capture_stop;
  assign beat_accept     = s00_axis.tvalid && s00_axis.tready;
  assign end_full        = (addr_reg == LAST_ADDR) && (CIRCULAR == 0);
  assign end_frame       = s00_axis.tlast && (STOP_ON_TLAST != 0);
  assign tap_edge        = tap_shift ^ tap_shift_reg;
  assign shift_en        = beat_accept || tap_edge;
  assign shift_in        = beat_accept ? s00_axis.tdata : last_word_reg;

  assign bram_clk   = s00_axis_aclk;
  assign bram_en    = bram_en_reg;
  assign bram_we    = bram_we_reg;
  assign bram_addr  = bram_addr_reg;
  assign bram_wdata = bram_wdata_reg;
  assign word_count = word_count_reg;
  assign frame_done = frame_done_reg;
  assign frame_len  = frame_len_reg;
  assign full       = full_reg;
  assign wrapped    = wrapped_reg;
  assign busy       = (state_reg == CAPTURE);
  assign tap_out    = tap_reg[tap_sel];

  // Capture state register.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) state_reg <= IDLE;
    else                 state_reg <= state_next;
  end

  // Next state: start re-arms from anywhere; full or a terminating TLAST ends capture.
  always_comb begin
    state_next = state_reg;
    if (capture_start) begin
      state_next = CAPTURE;
    end else begin
      case (state_reg)
        CAPTURE: begin
          if (capture_stop)                                  state_next = IDLE;
          else if (beat_accept && (end_full || end_frame))   state_next = DONE;
        end
        default: ;
      endcase
    end
  end

  // BRAM write port: one registered write per accepted beat; address/data hold otherwise.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      bram_en_reg    <= 1'b0;
      bram_we_reg    <= '0;
      bram_addr_reg  <= '0;
      bram_wdata_reg <= '0;
      last_word_reg  <= '0;
    end else begin
      bram_en_reg <= 1'b1;
      if (beat_accept) begin
        bram_we_reg    <= s00_axis.tstrb;
        bram_addr_reg  <= addr_reg;
        bram_wdata_reg <= s00_axis.tdata;
        last_word_reg  <= s00_axis.tdata;
      end else begin
        bram_we_reg <= '0;
      end
    end
  end

  // Address, counters and frame tracking; frame_len survives a restart.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      addr_reg       <= '0;
      word_count_reg <= '0;
      frame_cnt_reg  <= '0;
      frame_len_reg  <= '0;
      frame_done_reg <= 1'b0;
      full_reg       <= 1'b0;
      wrapped_reg    <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (capture_start) begin
        addr_reg       <= '0;
        word_count_reg <= '0;
        frame_cnt_reg  <= '0;
        full_reg       <= 1'b0;
        wrapped_reg    <= 1'b0;
      end else if (beat_accept) begin
        if (word_count_reg != MAX_COUNT) word_count_reg <= word_count_reg + 1'b1;
        if (addr_reg == LAST_ADDR) begin
          if (CIRCULAR != 0) begin
            addr_reg    <= '0;
            wrapped_reg <= 1'b1;
          end else begin
            full_reg <= 1'b1;
          end
        end else begin
          addr_reg <= addr_reg + 1'b1;
        end
        if (s00_axis.tlast) begin
          frame_len_reg  <= frame_cnt_reg + 1'b1;
          frame_cnt_reg  <= '0;
          frame_done_reg <= 1'b1;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Tap chain wiring: head takes the new word, every other stage its predecessor.
  for (genvar gi = 0; gi < TAP_DEPTH; gi++) begin : g_tap
    if (gi == 0) begin : g_head
      assign tap_in[gi] = shift_in;
    end else begin : g_body
      assign tap_in[gi] = tap_reg[gi-1];
    end
  end

  // Tap buffer shifts once per cycle on a beat and/or a tap_shift toggle.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      tap_shift_reg <= 1'b0;
      for (int i = 0; i < TAP_DEPTH; i++) tap_reg[i] <= '0;
    end else begin
      tap_shift_reg <= tap_shift;
      if (shift_en) begin
        for (int i = 0; i < TAP_DEPTH; i++) tap_reg[i] <= tap_in[i];
      end
    end
  end

endmodule

// File: tb/tb_axis_bram_capture_v2.sv
// Bench: three capture instances (single-shot, circular, stop-on-TLAST), all 8 words
// deep, share one stimulus stream; a queue-free behavioural model tracks each one.
module tb_axis_bram_capture_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast, tvalid, start, stop, tap_shift;
  logic [3:0]  tap_sel;

  logic        d_tready [3];
  logic        d_clk    [3];
  logic        d_en     [3];
  logic [3:0]  d_we     [3];
  logic [3:0]  d_addr   [3];
  logic [31:0] d_wdata  [3];
  logic [4:0]  d_wc     [3];
  logic        d_fd     [3];
  logic [4:0]  d_flen   [3];
  logic        d_full   [3];
  logic        d_wrap   [3];
  logic        d_busy   [3];
  logic [31:0] d_tap    [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    axis_bram_capture_v2_if #(.DATA_WIDTH(32)) axis ();
    assign axis.tdata   = tdata;
    assign axis.tstrb   = tstrb;
    assign axis.tlast   = tlast;
    assign axis.tvalid  = tvalid;
    assign d_tready[gi] = axis.tready;

    axis_bram_capture_v2 #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .BRAM_WORDS(8), .TAP_DEPTH(16),
      .CIRCULAR((gi == 1) ? 1 : 0), .STOP_ON_TLAST((gi == 2) ? 1 : 0)
    ) dut (
      .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(axis),
      .capture_start(start), .capture_stop(stop), .tap_shift(tap_shift),
      .tap_sel(tap_sel), .tap_out(d_tap[gi]), .bram_clk(d_clk[gi]),
      .bram_en(d_en[gi]), .bram_we(d_we[gi]), .bram_addr(d_addr[gi]),
      .bram_wdata(d_wdata[gi]), .word_count(d_wc[gi]), .frame_done(d_fd[gi]),
      .frame_len(d_flen[gi]), .full(d_full[gi]), .wrapped(d_wrap[gi]), .busy(d_busy[gi])
    );
  end

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 capturing, 2 finished (waiting for a restart)
  int          m_mode [3];
  int          m_addr [3];
  int          m_cnt  [3];
  int          m_fcnt [3];
  int          m_flen [3];
  bit          m_full [3];
  bit          m_wrap [3];
  logic [31:0] m_last [3];
  logic [31:0] m_tap  [3][16];
  logic        m_prev_ts;
  bit          e_en   [3];
  bit          e_fd   [3];
  logic [3:0]  e_we   [3];
  int          e_addr [3];
  logic [31:0] e_wdata[3];

  task automatic model_reset();
    m_prev_ts = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_addr[k] = 0; m_cnt[k] = 0; m_fcnt[k] = 0; m_flen[k] = 0;
      m_full[k] = 0; m_wrap[k] = 0; m_last[k] = '0;
      e_en[k] = 0; e_fd[k] = 0; e_we[k] = '0; e_addr[k] = 0; e_wdata[k] = '0;
      for (int i = 0; i < 16; i++) m_tap[k][i] = '0;
    end
  endtask

  function automatic bit ready_exp(int k);
    return (m_mode[k] == 1) && !start && !stop;
  endfunction

  task automatic compare(input int k);
    chk("tready",     k, 64'(d_tready[k]), 64'(ready_exp(k)));
    chk("bram_clk",   k, 64'(d_clk[k]),    64'(clk));
    chk("bram_en",    k, 64'(d_en[k]),     64'(e_en[k]));
    chk("bram_we",    k, 64'(d_we[k]),     64'(e_we[k]));
    chk("bram_addr",  k, 64'(d_addr[k]),   64'(e_addr[k]));
    chk("bram_wdata", k, 64'(d_wdata[k]),  64'(e_wdata[k]));
    chk("word_count", k, 64'(d_wc[k]),     64'(m_cnt[k]));
    chk("frame_done", k, 64'(d_fd[k]),     64'(e_fd[k]));
    chk("frame_len",  k, 64'(d_flen[k]),   64'(m_flen[k]));
    chk("full",       k, 64'(d_full[k]),   64'(m_full[k]));
    chk("wrapped",    k, 64'(d_wrap[k]),   64'(m_wrap[k]));
    chk("busy",       k, 64'(d_busy[k]),   64'(m_mode[k] == 1));
    chk("tap_out",    k, 64'(d_tap[k]),    64'(m_tap[k][tap_sel]));
  endtask

  // Advance one clock using the inputs that are stable up to the next rising edge.
  task automatic step(input int k);
    bit acc, tgl, fin;
    acc = ready_exp(k) && tvalid;
    tgl = (tap_shift != m_prev_ts);
    e_en[k] = 1;
    e_fd[k] = 0;
    if (acc) begin
      e_we[k] = tstrb; e_addr[k] = m_addr[k]; e_wdata[k] = tdata;
    end else begin
      e_we[k] = '0;
    end
    if (acc || tgl) begin
      for (int i = 15; i > 0; i--) m_tap[k][i] = m_tap[k][i-1];
      m_tap[k][0] = acc ? tdata : m_last[k];
    end
    if (acc) m_last[k] = tdata;
    if (start) begin
      m_mode[k] = 1; m_addr[k] = 0; m_cnt[k] = 0; m_fcnt[k] = 0; m_full[k] = 0; m_wrap[k] = 0;
    end else if (stop && m_mode[k] == 1) begin
      m_mode[k] = 0;
    end else if (acc) begin
      fin = 0;
      if (m_cnt[k] < 8) m_cnt[k]++;
      if (m_addr[k] == 7) begin
        if (k == 1) begin m_addr[k] = 0; m_wrap[k] = 1; end
        else begin m_full[k] = 1; fin = 1; end
      end else begin
        m_addr[k]++;
      end
      m_fcnt[k]++;
      if (tlast) begin
        m_flen[k] = m_fcnt[k]; m_fcnt[k] = 0; e_fd[k] = 1;
        if (k == 2) fin = 1;
      end
      if (fin) m_mode[k] = 2;
    end
  endtask

  // Compare process: on every falling edge check all outputs, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      for (int k = 0; k < 3; k++) compare(k);
      if (!rst) begin
        for (int k = 0; k < 3; k++) step(k);
        m_prev_ts = tap_shift;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    tvalid = 1'b1; tdata = d; tstrb = s; tlast = l;
    $display("beat data=%08h strb=%h last=%0d ready=%0d%0d%0d",
             d, s, l, d_tready[0], d_tready[1], d_tready[2]);
    tick();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic tap_chk(input logic [3:0] sel, input logic [31:0] exp);
    tap_sel = sel;
    #1;
    chk("tap_lit", 1, 64'(d_tap[1]), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; tvalid = 0; tdata = '0; tstrb = '0; tlast = 0;
    start = 0; stop = 0; tap_shift = 0; tap_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 0, 64'(d_en[0]), 64'd0);
    chk("rst_wc", 1, 64'(d_wc[1]), 64'd0);
    chk("rst_we", 2, 64'(d_we[2]), 64'd0);
    rst = 1'b0;
    tick(); tick();
    chk("en_after_rst", 0, 64'(d_en[0]), 64'd1);

    // Four beats written to addresses 0..3, one cycle after each acceptance.
    pulse_start();
    chk("busy_start", 0, 64'(d_busy[0]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      beat(32'hA0 + 32'(i), 4'hF, 1'b0);
      chk("t1_we",    0, 64'(d_we[0]),    64'hF);
      chk("t1_addr",  0, 64'(d_addr[0]),  64'(i));
      chk("t1_wdata", 0, 64'(d_wdata[0]), 64'hA0 + 64'(i));
    end
    chk("t1_wc",   0, 64'(d_wc[0]),   64'd4);
    chk("t1_busy", 0, 64'(d_busy[0]), 64'd1);

    // Six more beats: single-shot fills at 8, circular wraps to address 1.
    for (int i = 4; i < 10; i++) beat(32'hB0 + 32'(i), 4'(i) | 4'h1, 1'b0);
    chk("t2_full0",  0, 64'(d_full[0]),   64'd1);
    chk("t2_busy0",  0, 64'(d_busy[0]),   64'd0);
    chk("t2_rdy0",   0, 64'(d_tready[0]), 64'd0);
    chk("t2_we0",    0, 64'(d_we[0]),     64'd0);
    chk("t2_addr0",  0, 64'(d_addr[0]),   64'd7);
    chk("t2_wrap1",  1, 64'(d_wrap[1]),   64'd1);
    chk("t2_wc1",    1, 64'(d_wc[1]),     64'd8);
    chk("t2_addr1",  1, 64'(d_addr[1]),   64'd1);
    chk("t2_we1",    1, 64'(d_we[1]),     64'd9);
    pulse_start();
    chk("t2_clr_full", 0, 64'(d_full[0]), 64'd0);
    chk("t2_clr_wrap", 1, 64'(d_wrap[1]), 64'd0);
    chk("t2_clr_wc",   0, 64'(d_wc[0]),   64'd0);

    // Frames of 3 and 5 beats; the 5-beat frame ends exactly on the last address.
    for (int i = 0; i < 3; i++) beat(32'hC0 + 32'(i), 4'hF, i == 2);
    chk("f1_done",  0, 64'(d_fd[0]),     64'd1);
    chk("f1_len",   0, 64'(d_flen[0]),   64'd3);
    chk("f1_stop2", 2, 64'(d_busy[2]),   64'd0);
    chk("f1_rdy2",  2, 64'(d_tready[2]), 64'd0);
    for (int i = 0; i < 5; i++) beat(32'hD0 + 32'(i), 4'h3, i == 4);
    chk("f2_done",  0, 64'(d_fd[0]),   64'd1);
    chk("f2_len",   0, 64'(d_flen[0]), 64'd5);
    chk("f2_full",  0, 64'(d_full[0]), 64'd1);
    chk("f2_busy",  0, 64'(d_busy[0]), 64'd0);
    chk("f2_len2",  2, 64'(d_flen[2]), 64'd3);
    chk("f2_wrap1", 1, 64'(d_wrap[1]), 64'd1);

    // Start together with a valid beat: the beat is refused.
    start = 1'b1; tvalid = 1'b1; tdata = 32'hEE; tstrb = 4'hF;
    tick();
    start = 1'b0; tvalid = 1'b0;
    chk("sv_we0",   0, 64'(d_we[0]),   64'd0);
    chk("sv_we1",   1, 64'(d_we[1]),   64'd0);
    chk("sv_busy2", 2, 64'(d_busy[2]), 64'd1);
    beat(32'hE0, 4'hF, 1'b0);
    chk("sv_addr0", 0, 64'(d_addr[0]), 64'd0);
    chk("sv_we0b",  0, 64'(d_we[0]),   64'hF);
    chk("sv_addr1", 1, 64'(d_addr[1]), 64'd0);

    // Stop aborts capture; a following beat is not accepted.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", 0, 64'(d_busy[0]),   64'd0);
    chk("stop_rdy",  1, 64'(d_tready[1]), 64'd0);
    beat(32'hE1, 4'hF, 1'b0);
    chk("stop_we", 0, 64'(d_we[0]), 64'd0);
    chk("stop_wc", 0, 64'(d_wc[0]), 64'd1);

    // Tap buffer: 16 beats, then two toggles that re-insert the last word.
    pulse_start();
    for (int i = 1; i <= 16; i++) beat(32'(i), 4'hF, 1'b0);
    tap_shift = 1'b1; tick();
    tap_shift = 1'b0; tick();
    tap_chk(4'd0, 32'd16);
    tap_chk(4'd3, 32'd15);
    tap_chk(4'd4, 32'd14);
    // Toggle coincident with a beat: exactly one shift.
    tap_shift = 1'b1;
    beat(32'd17, 4'hF, 1'b0);
    tap_chk(4'd0, 32'd17);
    tap_chk(4'd3, 32'd16);
    tap_chk(4'd4, 32'd15);

    // Asynchronous reset mid-capture clears everything at once.
    beat(32'h55, 4'hF, 1'b0);
    rst = 1'b1; tap_shift = 1'b0;
    #1;
    chk("ar_we",   1, 64'(d_we[1]),   64'd0);
    chk("ar_busy", 1, 64'(d_busy[1]), 64'd0);
    chk("ar_wc",   1, 64'(d_wc[1]),   64'd0);
    chk("ar_tap",  1, 64'(d_tap[1]),  64'd0);
    chk("ar_en",   1, 64'(d_en[1]),   64'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
